i2c_multi_slave_sequencer: RTL and testbench

//  Parametrised successor to the single-slave controller between I2C_Master and the RAM controller.

---
 rtl/i2c_multi_slave_sequencer_if.sv | 39 +++
 rtl/i2c_multi_slave_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_multi_slave_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_multi_slave_sequencer_if.sv
// Bus bundle between the multi-slave sequencer, the I2C byte master and the RAM.
// The master modport is the sequencer side; the slave modport is the
// I2C master / RAM side.
interface i2c_multi_slave_sequencer_if #(
    parameter int RAM_AW = 8
);
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    logic              Master_Go;
    logic              Master_Stop;
    logic              Master_RW;
    logic [5:0]        Master_NumOfBytes;
    logic [6:0]        Master_SlaveAddr;
    logic [7:0]        Master_SlaveRegAddr;
    logic [7:0]        Master_DataWriteReg;
    logic              Master_Ready;
    logic              Master_Done;
    logic              Master_ACK;
    logic [7:0]        Master_ReadData;

    modport master (
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata,
        output Master_Go, Master_Stop, Master_RW, Master_NumOfBytes,
        output Master_SlaveAddr, Master_SlaveRegAddr, Master_DataWriteReg,
        input  Master_Ready, Master_Done, Master_ACK, Master_ReadData
    );

    modport slave (
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata,
        input  Master_Go, Master_Stop, Master_RW, Master_NumOfBytes,
        input  Master_SlaveAddr, Master_SlaveRegAddr, Master_DataWriteReg,
        output Master_Ready, Master_Done, Master_ACK, Master_ReadData
    );
endinterface

// File: rtl/i2c_multi_slave_sequencer.sv
// Multi-slave I2C burst sequencer: walks a list of slaves, doing one burst of
// BYTES_PER_SLAVE bytes per enabled slave, reading into or writing from a
// per-slave RAM window. Handles NACK / timeout per slave, loop and abort.
module i2c_multi_slave_sequencer #(
    parameter int         NUM_SLAVES      = 4,
    parameter int         BYTES_PER_SLAVE = 16,
    parameter int         RAM_AW          = 8,
    parameter logic [7:0] BASE_REG        = 8'h00,
    parameter int         TIMEOUT_CYCLES  = 200000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    loop,
    input  logic                    abort,
    input  logic [7*NUM_SLAVES-1:0] slave_addr_list,
    input  logic [NUM_SLAVES-1:0]   enable_mask,
    input  logic [NUM_SLAVES-1:0]   rw_mask,
    i2c_multi_slave_sequencer_if.master bus,
    output logic                    busy,
    output logic                    pass_done,
    output logic [NUM_SLAVES-1:0]   err_flags,
    output logic [2:0]              cur_slave
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_WAIT_RDY,
        ST_ISSUE,
        ST_XFER,
        ST_NEXT,
        ST_FINISH
    } state_t;

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_SLAVES);
    localparam logic [5:0]  LAST_BYTE = 6'(BYTES_PER_SLAVE - 1);
    localparam logic [5:0]  NBYTES    = 6'(BYTES_PER_SLAVE);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t state, state_d;

    logic [3:0]              idx, idx_d;
    logic [2:0]              sel;
    logic [5:0]              byte_cnt, byte_d;
    logic [31:0]             timer, timer_d;
    logic [NUM_SLAVES-1:0]   en_q, en_d, rw_q, rw_d, err_q, err_d;
    logic [7*NUM_SLAVES-1:0] list_q, list_d;

    logic [RAM_AW-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              go_q, go_d;
    logic              stop_q, stop_d;
    logic              mrw_q, mrw_d;
    logic [5:0]        nbytes_q, nbytes_d;
    logic [6:0]        saddr_q, saddr_d;
    logic [7:0]        regaddr_q, regaddr_d;
    logic [7:0]        dwr_q, dwr_d;
    logic              busy_q, busy_d;
    logic              pdone_q, pdone_d;
    logic [2:0]        cur_q, cur_d;

    logic                    en_cur, rw_cur;
    logic [NUM_SLAVES-1:0]   en_shift, rw_shift, err_bit;
    logic [7*NUM_SLAVES-1:0] list_shift;

    function automatic logic [RAM_AW-1:0] win_addr(input logic [2:0] s, input logic [5:0] b);
        return RAM_AW'(32'(s) * 32'(BYTES_PER_SLAVE) + 32'(b));
    endfunction

    assign sel = idx[2:0];

    // Per-slave views of the latched masks and address list for the current index.
    always_comb begin
        en_shift   = en_q >> sel;
        rw_shift   = rw_q >> sel;
        list_shift = list_q >> (32'(sel) * 32'd7);
        err_bit    = NUM_SLAVES'(1) << sel;
        en_cur     = en_shift[0];
        rw_cur     = rw_shift[0];
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        byte_d    = byte_cnt;
        timer_d   = timer;
        en_d      = en_q;
        rw_d      = rw_q;
        list_d    = list_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        go_d      = 1'b0;
        stop_d    = 1'b0;
        mrw_d     = mrw_q;
        nbytes_d  = nbytes_q;
        saddr_d   = saddr_q;
        regaddr_d = regaddr_q;
        dwr_d     = dwr_q;
        busy_d    = busy_q;
        pdone_d   = 1'b0;
        cur_d     = cur_q;

        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_SELECT;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    idx_d   = '0;
                    en_d    = enable_mask;
                    rw_d    = rw_mask;
                    list_d  = slave_addr_list;
                end
            end
            ST_SELECT: begin
                if (idx == LAST_IDX) begin
                    state_d = ST_FINISH;
                    pdone_d = 1'b1;
                end else if (!en_cur) begin
                    idx_d = idx + 4'd1;
                end else begin
                    state_d   = ST_WAIT_RDY;
                    addr_d    = win_addr(sel, 6'd0);
                    cur_d     = sel;
                    saddr_d   = list_shift[6:0];
                    mrw_d     = rw_cur;
                    nbytes_d  = NBYTES;
                    regaddr_d = BASE_REG;
                    byte_d    = '0;
                end
            end
            ST_WAIT_RDY: begin
                if (bus.Master_Ready) begin
                    state_d = ST_ISSUE;
                    go_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_XFER;
                byte_d  = '0;
                timer_d = '0;
                stop_d  = (LAST_BYTE == 6'd0);
            end
            ST_XFER: begin
                if (bus.Master_Done) begin
                    timer_d = '0;
                    if (bus.Master_ACK) begin
                        err_d   = err_q | err_bit;
                        stop_d  = 1'b1;
                        state_d = ST_NEXT;
                    end else begin
                        if (rw_cur) begin
                            we_d    = 1'b1;
                            wdata_d = bus.Master_ReadData;
                            addr_d  = win_addr(sel, byte_cnt);
                        end else begin
                            // Point at the next byte now so its RAM data is in place before it is sent.
                            addr_d = win_addr(sel, byte_cnt + 6'd1);
                        end
                        if (byte_cnt == LAST_BYTE) begin
                            state_d = ST_NEXT;
                        end else begin
                            byte_d = byte_cnt + 6'd1;
                            stop_d = ((byte_cnt + 6'd1) == LAST_BYTE);
                        end
                    end
                end else if (timer == TMO_LAST) begin
                    err_d   = err_q | err_bit;
                    stop_d  = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    timer_d = timer + 32'd1;
                    stop_d  = (byte_cnt == LAST_BYTE);
                end
            end
            ST_NEXT: begin
                idx_d   = idx + 4'd1;
                state_d = ST_SELECT;
            end
            ST_FINISH: begin
                if (loop) begin
                    state_d = ST_SELECT;
                    idx_d   = '0;
                    err_d   = '0;
                    en_d    = enable_mask;
                    rw_d    = rw_mask;
                    list_d  = slave_addr_list;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Write-mode data follows the RAM read port while a write burst is set up or running.
        if ((state == ST_WAIT_RDY || state == ST_ISSUE || state == ST_XFER) && !rw_cur) begin
            dwr_d = bus.ram_rdata;
        end

        // Abort overrides everything, including a byte completing in the same cycle.
        if (abort && state != ST_IDLE) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
            go_d    = 1'b0;
            we_d    = 1'b0;
            pdone_d = 1'b0;
            err_d   = err_q;
            addr_d  = addr_q;
            wdata_d = wdata_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            byte_cnt  <= '0;
            timer     <= '0;
            en_q      <= '0;
            rw_q      <= '0;
            list_q    <= '0;
            err_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            go_q      <= 1'b0;
            stop_q    <= 1'b0;
            mrw_q     <= 1'b0;
            nbytes_q  <= '0;
            saddr_q   <= '0;
            regaddr_q <= '0;
            dwr_q     <= '0;
            busy_q    <= 1'b0;
            pdone_q   <= 1'b0;
            cur_q     <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            byte_cnt  <= byte_d;
            timer     <= timer_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            list_q    <= list_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            go_q      <= go_d;
            stop_q    <= stop_d;
            mrw_q     <= mrw_d;
            nbytes_q  <= nbytes_d;
            saddr_q   <= saddr_d;
            regaddr_q <= regaddr_d;
            dwr_q     <= dwr_d;
            busy_q    <= busy_d;
            pdone_q   <= pdone_d;
            cur_q     <= cur_d;
        end
    end

    assign bus.ram_addr            = addr_q;
    assign bus.ram_wdata           = wdata_q;
    assign bus.ram_we              = we_q;
    assign bus.Master_Go           = go_q;
    assign bus.Master_Stop         = stop_q;
    assign bus.Master_RW           = mrw_q;
    assign bus.Master_NumOfBytes   = nbytes_q;
    assign bus.Master_SlaveAddr    = saddr_q;
    assign bus.Master_SlaveRegAddr = regaddr_q;
    assign bus.Master_DataWriteReg = dwr_q;
    assign busy                    = busy_q;
    assign pass_done               = pdone_q;
    assign err_flags               = err_q;
    assign cur_slave               = cur_q;

endmodule

// File: tb/tb_i2c_multi_slave_sequencer.sv
// Directed bench for i2c_multi_slave_sequencer: two slaves, 4-byte bursts,
// behavioural I2C byte master and 1-cycle-latency RAM.
module tb_i2c_multi_slave_sequencer;

    localparam int NS     = 2;
    localparam int BPS    = 4;
    localparam int TMO    = 40;
    localparam int BYTE_T = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, start, loop, abort;
    logic [7*NS-1:0] addr_list;
    logic [NS-1:0]   enable_mask, rw_mask, err_flags;
    logic            busy, pass_done;
    logic [2:0]      cur_slave;

    i2c_multi_slave_sequencer_if #(.RAM_AW(8)) bus();

    i2c_multi_slave_sequencer #(
        .NUM_SLAVES(NS), .BYTES_PER_SLAVE(BPS), .RAM_AW(8),
        .BASE_REG(8'h5A), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .loop(loop), .abort(abort),
        .slave_addr_list(addr_list), .enable_mask(enable_mask), .rw_mask(rw_mask),
        .bus(bus), .busy(busy), .pass_done(pass_done),
        .err_flags(err_flags), .cur_slave(cur_slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM: registered read, write from DUT or bench preload port
    logic [7:0] ram [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    always @(posedge clk) begin
        bus.ram_rdata <= ram[bus.ram_addr];
        if (pre_we) ram[pre_addr] = pre_data;
        else if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
    end

    task automatic ram_put(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic fill_ee();
        for (int i = 0; i < 8; i++) ram_put(8'(i), 8'hEE);
    endtask

    // Event monitors
    int         go_cnt, we_cnt, pass_cnt;
    logic [6:0] go_addr [8];
    logic       go_rw [8];
    logic [7:0] we_addr [16];
    always @(negedge clk) begin
        if (bus.Master_Go) begin
            if (go_cnt < 8) begin go_addr[go_cnt] = bus.Master_SlaveAddr; go_rw[go_cnt] = bus.Master_RW; end
            go_cnt++;
        end
        if (bus.ram_we) begin
            if (we_cnt < 16) we_addr[we_cnt] = bus.ram_addr;
            we_cnt++;
        end
        if (pass_done) pass_cnt++;
    end

    // Behavioural I2C byte master
    logic       mbusy;
    logic       hold_en, nack_en;
    logic [6:0] hold_addr, nack_addr;
    int         hold_byte, nack_byte, to_wait, log_n;
    logic       stop_after;
    logic       stop_log [16];
    logic [7:0] dwr_log [16];

    initial begin : master_model
        logic [6:0] m_addr;
        logic       hit;
        mbusy = 1'b0;
        bus.Master_Ready = 1'b1; bus.Master_Done = 1'b0;
        bus.Master_ACK = 1'b0; bus.Master_ReadData = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.Master_Go) begin
                mbusy = 1'b1; bus.Master_Ready = 1'b0; m_addr = bus.Master_SlaveAddr;
                for (int b = 0; b < BPS; b++) begin
                    if (hold_en && m_addr == hold_addr && b == hold_byte) begin
                        to_wait = 0;
                        while (!bus.Master_Stop && to_wait < 200) begin @(negedge clk); to_wait++; end
                        @(negedge clk);
                        stop_after = bus.Master_Stop;
                        break;
                    end
                    repeat (BYTE_T) @(negedge clk);
                    if (log_n < 16) begin
                        stop_log[log_n] = bus.Master_Stop;
                        dwr_log[log_n]  = bus.Master_DataWriteReg;
                    end
                    log_n++;
                    hit = nack_en && m_addr == nack_addr && b == nack_byte;
                    bus.Master_Done = 1'b1; bus.Master_ACK = hit;
                    bus.Master_ReadData = 8'h10 + 8'(b);
                    @(negedge clk);
                    bus.Master_Done = 1'b0; bus.Master_ACK = 1'b0;
                    if (hit) break;
                end
                bus.Master_Ready = 1'b1; mbusy = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        go_cnt = 0; we_cnt = 0; pass_cnt = 0; log_n = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || mbusy) && n < 20000) begin @(negedge clk); n++; end
        check(tag, 32'(n < 20000), 1);
    endtask

    task automatic run_pass(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        wait_idle({tag, "_idle"});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int w;
        reset = 1'b1; start = 1'b0; loop = 1'b0; abort = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        addr_list = {7'h49, 7'h48}; enable_mask = 2'b11; rw_mask = 2'b11;
        hold_en = 1'b0; nack_en = 1'b0; hold_addr = 7'h48; nack_addr = 7'h48;
        hold_byte = 1; nack_byte = 1; to_wait = 0; stop_after = 1'b1;
        clear_logs();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_pass_done", pass_done, 0);
        check("rst_err", err_flags, 0);
        check("rst_go", bus.Master_Go, 0);
        check("rst_stop", bus.Master_Stop, 0);
        check("rst_we", bus.ram_we, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_saddr", bus.Master_SlaveAddr, 0);
        check("rst_nbytes", bus.Master_NumOfBytes, 0);
        check("rst_cur", cur_slave, 0);
        reset = 1'b0;
        @(negedge clk);

        // T1: both slaves read
        fill_ee(); clear_logs();
        run_pass("t1");
        for (int i = 0; i < 8; i++) check("t1_ram", ram[i], 32'h10 + 32'(i % 4));
        check("t1_go_cnt", go_cnt, 2);
        check("t1_go_addr0", go_addr[0], 7'h48);
        check("t1_go_addr1", go_addr[1], 7'h49);
        check("t1_go_rw", go_rw[0], 1);
        check("t1_we_cnt", we_cnt, 8);
        check("t1_pass_cnt", pass_cnt, 1);
        check("t1_err", err_flags, 0);
        check("t1_cur", cur_slave, 1);
        check("t1_regaddr", bus.Master_SlaveRegAddr, 8'h5A);
        check("t1_nbytes", bus.Master_NumOfBytes, 4);

        // T2: only slave 1 enabled
        fill_ee(); clear_logs(); enable_mask = 2'b10;
        run_pass("t2");
        check("t2_go_cnt", go_cnt, 1);
        check("t2_go_addr", go_addr[0], 7'h49);
        check("t2_we_cnt", we_cnt, 4);
        check("t2_we_first", we_addr[0], 4);
        check("t2_we_last", we_addr[3], 7);
        check("t2_ram0", ram[0], 8'hEE);
        check("t2_ram4", ram[4], 8'h10);

        // T3: write slave 0 from RAM
        for (int i = 0; i < 4; i++) ram_put(8'(i), 8'hA0 + 8'(i));
        clear_logs(); enable_mask = 2'b01; rw_mask = 2'b00;
        run_pass("t3");
        check("t3_go_cnt", go_cnt, 1);
        check("t3_go_rw", go_rw[0], 0);
        check("t3_bytes", log_n, 4);
        for (int i = 0; i < 4; i++) check("t3_dwr", dwr_log[i], 32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) check("t3_stop", stop_log[i], (i == 3) ? 1 : 0);
        check("t3_we_cnt", we_cnt, 0);

        // T4: NACK on slave 0 byte 1
        fill_ee(); clear_logs(); enable_mask = 2'b11; rw_mask = 2'b11; nack_en = 1'b1;
        run_pass("t4");
        nack_en = 1'b0;
        check("t4_err", err_flags, 2'b01);
        check("t4_ram0", ram[0], 8'h10);
        check("t4_ram1", ram[1], 8'hEE);
        check("t4_ram3", ram[3], 8'hEE);
        check("t4_ram4", ram[4], 8'h10);
        check("t4_ram7", ram[7], 8'h13);
        check("t4_go_cnt", go_cnt, 2);
        check("t4_we_cnt", we_cnt, 5);

        // T5: Done withheld on slave 0 byte 1
        fill_ee(); clear_logs(); hold_en = 1'b1;
        run_pass("t5");
        hold_en = 1'b0;
        check("t5_err", err_flags, 2'b01);
        check("t5_wait", to_wait, TMO);
        check("t5_stop_pulse", stop_after, 0);
        check("t5_go_cnt", go_cnt, 2);
        check("t5_ram1", ram[1], 8'hEE);
        check("t5_ram5", ram[5], 8'h11);
        check("t5_pass_cnt", pass_cnt, 1);

        // T6a: loop gives back-to-back passes
        clear_logs(); loop = 1'b1;
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (!pass_done && n < 5000) begin @(negedge clk); n++; end
        check("t6_pd1", 32'(n < 5000), 1);
        @(negedge clk);
        check("t6_busy_kept", busy, 1);
        n = 0;
        while (!pass_done && n < 5000) begin @(negedge clk); n++; end
        check("t6_pd2", 32'(n < 5000), 1);
        loop = 1'b0;
        wait_idle("t6_loop_idle");
        check("t6_pass_cnt", pass_cnt, 2);
        check("t6_go_cnt", go_cnt, 4);
        check("t6_we_cnt", we_cnt, 16);

        // T6b: start and abort together in IDLE
        start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
        check("t6_start_abort", busy, 0);

        // T6c: abort mid-transfer
        clear_logs();
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (we_cnt < 2 && n < 5000) begin @(negedge clk); n++; end
        check("t6_abort_reach", 32'(n < 5000), 1);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_stop", bus.Master_Stop, 1);
        w = we_cnt;
        @(negedge clk);
        check("t6_abort_stop_end", bus.Master_Stop, 0);
        wait_idle("t6_abort_idle");
        check("t6_abort_we", we_cnt, w);
        check("t6_abort_go", go_cnt, 1);
        check("t6_abort_pd", pass_cnt, 0);

        // T6d: reset mid-pass
        clear_logs();
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (we_cnt < 1 && n < 5000) begin @(negedge clk); n++; end
        check("t6_rst_reach", 32'(n < 5000), 1);
        reset = 1'b1; @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_wdata", bus.ram_wdata, 0);
        check("t6_rst_addr", bus.ram_addr, 0);
        check("t6_rst_saddr", bus.Master_SlaveAddr, 0);
        check("t6_rst_rw", bus.Master_RW, 0);
        check("t6_rst_we", bus.ram_we, 0);
        reset = 1'b0;
        wait_idle("t6_rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
